width_adjust_arbiter: RTL
=========================

# width_adjust_arbiter

Two-port, round-robin arbiter that shares one output stream between two requesters of different word widths. Each granted word is width-adjusted to WORD_WIDTH_OUT: zero-padded, sign-extended or truncated, according to per-port parameters. The adjusted word is held in a single registered output stage with a valid/ready handshake. The block sits where narrow and wide producers feed a common fixed-width datapath.

## Interface
- WORD_WIDTH_A, default 0: width of port A data; must be ≥ 1.
- SIGNED_A, default 0: non-zero means port A words are sign-extended when padded.
- WORD_WIDTH_B, default 0: width of port B data; must be ≥ 1.
- SIGNED_B, default 0: non-zero means port B words are sign-extended when padded.
- WORD_WIDTH_OUT, default 0: output word width; must be ≥ 1.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- clear  in  1  reset; asynchronous, active-high.
- a_valid  in  1  port A word offered.
- a_ready  out  1  port A word accepted this cycle when a_valid and a_ready are both high.
- a_data  in  WORD_WIDTH_A  port A word.
- b_valid  in  1  port B word offered.
- b_ready  out  1  port B word accepted this cycle when b_valid and b_ready are both high.
- b_data  in  WORD_WIDTH_B  port B word.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  WORD_WIDTH_OUT  adjusted word.
- out_source  out  1  origin of out_data: 0 = A, 1 = B.

## Operation
- Width rule, applied independently per port with PAD = WORD_WIDTH_OUT − WORD_WIDTH_port:
  - PAD = 0: pass the word through unchanged.
  - PAD > 0, SIGNED non-zero and input MSB = 1: fill upper PAD bits with ones.
  - PAD > 0, all other cases: fill upper PAD bits with zeros.
  - PAD < 0: keep the low WORD_WIDTH_OUT bits and discard the rest.
- Output stage: a single register for out_data/out_source plus the out_valid flag.
- load_ok = !out_valid || out_ready. The stage can accept a new word when it is empty or is being drained in the same cycle.
- Grant, combinational, priority register `prio`:
  - Only one of a_valid/b_valid high: that port is granted.
  - Both high: the port named by prio is granted.
  - Neither high: no grant.
- a_ready = load_ok && grant_A; b_ready = load_ok && grant_B. At most one ready is high in any cycle.
- On an accept:
  - out_data ← adjusted word; out_source ← granted port; out_valid ← 1.
  - prio ← the port *not* granted.
- Drain with no accept: out_valid ← 0. out_data and out_source hold their values.
- Simultaneous drain and accept: the new word replaces the old one in the same edge and out_valid stays 1.
- prio changes only on an accept. An idle or stalled cycle leaves it unchanged.
- Ready depends on the valids and on out_ready, so there are combinational paths from input to ready. No path exists from any input to out_valid, out_data or out_source.
- No ready is high while clear is asserted.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_source = 0, prio = A. a_ready and b_ready are forced to 0 while clear is high.
- Latency: a word accepted at edge N appears on out_data, with out_valid high, from edge N onward, i.e. one cycle after it was presented.
- Throughput: one word per cycle with out_ready held high.
- Fairness: with both ports continuously valid, grants alternate A, B, A, B, ...
- Backpressure: out_valid high and out_ready low means out_data/out_source are stable and both readys are 0.
- Reset mid-operation: clear asynchronously drops out_valid and discards any held word. The first accept after clear deasserts follows reset priority, i.e. A first.

## Test plan
Configuration for all scenarios: WORD_WIDTH_A=8, SIGNED_A=1, WORD_WIDTH_B=20, SIGNED_B=0, WORD_WIDTH_OUT=16.

- Port A alone: present 0x80, then 0x7F, with out_ready=1 → out_data 0xFF80 then 0x007F, out_source=0, one cycle after each accept.
- Port B alone: present 0xABCDE, then 0x00123 → out_data 0xBCDE then 0x0123, out_source=1.
- Both ports valid for 4 cycles with out_ready=1 → outputs A, B, A, B in order. Exactly one ready is high each cycle.
- Backpressure: hold out_ready=0 for 3 cycles while A presents 0x01 → out_data stays 0x0001, a_ready=0 and b_ready=0 during the stall. On release the next word loads in the same cycle the held word drains, and out_valid stays high.
- Fairness across a stall: B is granted, then a stall, then both ports valid → A is granted next, because prio is unchanged by the stall.
- Reset mid-operation: assert clear for 1 cycle, off the clock edge, while out_valid=1 → out_valid, out_data and out_source drop to 0 immediately. With both ports valid afterwards, A is granted first.

Source files
------------

// File: rtl/width_adjust_arbiter_if.sv
// Stream bundle for width_adjust_arbiter: two producer ports in, one adjusted stream out.
// slave = arbiter side, master = producer/consumer side.
interface width_adjust_arbiter_if #(
  parameter int WORD_WIDTH_A   = 0,
  parameter int WORD_WIDTH_B   = 0,
  parameter int WORD_WIDTH_OUT = 0
);
  logic                      a_valid;
  logic                      a_ready;
  logic [WORD_WIDTH_A-1:0]   a_data;
  logic                      b_valid;
  logic                      b_ready;
  logic [WORD_WIDTH_B-1:0]   b_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WORD_WIDTH_OUT-1:0] out_data;
  logic                      out_source;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_source
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_source
  );
endinterface

// File: rtl/width_adjust_arbiter.sv
// Round-robin 2:1 arbiter with per-port width adjust into one registered output stage.
// Latency 1 cycle; readies drop while the held word is stalled (out_valid && !out_ready).
module width_adjust_arbiter #(
  parameter int WORD_WIDTH_A   = 0,
  parameter int SIGNED_A       = 0,
  parameter int WORD_WIDTH_B   = 0,
  parameter int SIGNED_B       = 0,
  parameter int WORD_WIDTH_OUT = 0
) (
  input  logic                  clock,
  input  logic                  clear,
  width_adjust_arbiter_if.slave bus
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  localparam int PAD_A = WORD_WIDTH_OUT - WORD_WIDTH_A;
  localparam int PAD_B = WORD_WIDTH_OUT - WORD_WIDTH_B;

  prio_e                     r_prio;
  prio_e                     w_prio_nxt;
  logic                      r_out_valid;
  logic                      r_out_source;
  logic [WORD_WIDTH_OUT-1:0] r_out_data;

  logic [WORD_WIDTH_OUT-1:0] w_a_adj;
  logic [WORD_WIDTH_OUT-1:0] w_b_adj;
  logic                      w_load_ok;
  logic                      w_grant_a;
  logic                      w_grant_b;
  logic                      w_accept_a;
  logic                      w_accept_b;
  logic                      w_accept;

  // Width adjust for port A: pass, pad (sign or zero), or truncate to the low bits.
  generate
    if (PAD_A == 0) begin : g_a_pass
      assign w_a_adj = bus.a_data;
    end else if (PAD_A > 0) begin : g_a_pad
      logic w_a_fill;
      assign w_a_fill = (SIGNED_A != 0) && bus.a_data[WORD_WIDTH_A-1];
      assign w_a_adj  = {{PAD_A{w_a_fill}}, bus.a_data};
    end else begin : g_a_trunc
      assign w_a_adj = bus.a_data[WORD_WIDTH_OUT-1:0];
    end
  endgenerate

  generate
    if (PAD_B == 0) begin : g_b_pass
      assign w_b_adj = bus.b_data;
    end else if (PAD_B > 0) begin : g_b_pad
      logic w_b_fill;
      assign w_b_fill = (SIGNED_B != 0) && bus.b_data[WORD_WIDTH_B-1];
      assign w_b_adj  = {{PAD_B{w_b_fill}}, bus.b_data};
    end else begin : g_b_trunc
      assign w_b_adj = bus.b_data[WORD_WIDTH_OUT-1:0];
    end
  endgenerate

  // The stage can take a word when empty or when its current word leaves this cycle.
  assign w_load_ok  = !r_out_valid || bus.out_ready;
  assign w_grant_a  = bus.a_valid && (!bus.b_valid || (r_prio == PRIO_A));
  assign w_grant_b  = bus.b_valid && (!bus.a_valid || (r_prio == PRIO_B));
  assign w_accept_a = w_load_ok && w_grant_a && !clear;
  assign w_accept_b = w_load_ok && w_grant_b && !clear;
  assign w_accept   = w_accept_a || w_accept_b;

  assign bus.a_ready    = w_accept_a;
  assign bus.b_ready    = w_accept_b;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.out_source = r_out_source;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_prio <= PRIO_A;
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

  // Priority moves to the loser only when a word is actually taken.
  always_comb begin
    w_prio_nxt = r_prio;
    if (w_accept_a) begin
      w_prio_nxt = PRIO_B;
    end else if (w_accept_b) begin
      w_prio_nxt = PRIO_A;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_source <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_accept_b ? w_b_adj : w_a_adj;
      r_out_source <= w_accept_b;
    end else if (bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

endmodule
